// File: rtl/sio_uart.sv
// sio_uart: fixed-baud 8N1 UART with a single-byte transmitter and a small receive FIFO.
module sio_uart #(
  parameter int DIVIDER  = 1250,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       reg_dat_we,
  input  logic [7:0] reg_dat_di,
  input  logic       reg_dat_re,
  output logic [7:0] reg_dat_do,
  output logic       reg_dat_wait,
  output logic       recv_buf_valid,
  output logic       tdre,
  output logic       rx_overrun
);
  localparam int CW = $clog2(DIVIDER);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIVIDER / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t       r_tx_state;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_ser_tx;
  logic            r_tdre;

  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            r_rx_s1;
  logic            r_rx_s2;

  logic [AW:0]     r_wp;
  logic [AW:0]     r_rp;
  logic [7:0]      r_mem [RX_DEPTH];
  logic            r_valid;
  logic            r_overrun;

  logic            w_push;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;
  logic [AW:0]     w_wp_nxt;
  logic [AW:0]     w_rp_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_ser_tx   <= 1'b1;
      r_tdre     <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (reg_dat_we) begin
          r_tx_shift <= reg_dat_di;
          r_tdre     <= 1'b0;
          r_ser_tx   <= 1'b0;
          r_tx_cnt   <= '0;
          r_tx_state <= TX_START;
        end
        TX_START: if (r_tx_cnt == C_FULL) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_ser_tx   <= r_tx_shift[0];
          r_tx_state <= TX_DATA;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        TX_DATA: if (r_tx_cnt == C_FULL) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 3'd7) begin
            r_ser_tx   <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_ser_tx   <= r_tx_shift[1];
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        TX_STOP: if (r_tx_cnt == C_FULL) begin
          r_tx_cnt   <= '0;
          r_tdre     <= 1'b1;
          r_tx_state <= TX_IDLE;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // START samples mid-bit so every later DIVIDER step lands mid-bit too
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= ser_rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        RX_IDLE: if (!r_rx_s2) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_START;
        end
        RX_START: if (r_rx_cnt == C_HALF) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (r_rx_cnt == C_FULL) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP: if (r_rx_cnt == C_FULL) begin
          r_rx_cnt   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_BREAK;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_BREAK: if (r_rx_s2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_push   = (r_rx_state == RX_STOP) && (r_rx_cnt == C_FULL) && r_rx_s2;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_pop    = reg_dat_re & ~w_empty;
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_wp_nxt = r_wp + {{AW{1'b0}}, w_wr};
  assign w_rp_nxt = r_rp + {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wp      <= w_wp_nxt;
      r_rp      <= w_rp_nxt;
      r_valid   <= w_wp_nxt != w_rp_nxt;
      r_overrun <= w_drop | (r_overrun & ~reg_dat_re);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= r_rx_shift;
  end

  assign ser_tx         = r_ser_tx;
  assign tdre           = r_tdre;
  assign recv_buf_valid = r_valid;
  assign rx_overrun     = r_overrun;
  assign reg_dat_wait   = reg_dat_we & ~r_tdre;
  assign reg_dat_do     = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
endmodule

// File: tb/tb_sio_uart.sv
// tb_sio_uart: directed checks of sio_uart with DIVIDER=16, RX_DEPTH=4.
module tb_sio_uart;
  logic       clk = 1'b0;
  logic       resetn;
  logic       ser_rx;
  logic       ser_tx;
  logic       reg_dat_we;
  logic [7:0] reg_dat_di;
  logic       reg_dat_re;
  logic [7:0] reg_dat_do;
  logic       reg_dat_wait;
  logic       recv_buf_valid;
  logic       tdre;
  logic       rx_overrun;
  int         tests = 0;
  int         fails = 0;

  sio_uart #(.DIVIDER(16), .RX_DEPTH(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .ser_rx(ser_rx),
    .ser_tx(ser_tx),
    .reg_dat_we(reg_dat_we),
    .reg_dat_di(reg_dat_di),
    .reg_dat_re(reg_dat_re),
    .reg_dat_do(reg_dat_do),
    .reg_dat_wait(reg_dat_wait),
    .recv_buf_valid(recv_buf_valid),
    .tdre(tdre),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic send_rx(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (16) @(negedge clk);
    end
    ser_rx = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    ser_rx = 1'b1;
    reg_dat_we = 1'b0;
    reg_dat_di = 8'h00;
    reg_dat_re = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ser_tx !== 1'b1) begin fails++; $display("FAIL reset_ser_tx got %b want 1", ser_tx); end
    tests++; if (tdre !== 1'b1) begin fails++; $display("FAIL reset_tdre got %b want 1", tdre); end
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", recv_buf_valid); end
    tests++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
    tests++; if (reg_dat_do !== 8'h00) begin fails++; $display("FAIL reset_do got %h want 00", reg_dat_do); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx;
    logic [9:0] exp;
    logic       err;
    logic       got;
    int         low;
    exp = {1'b1, 8'h41, 1'b0};
    low = 0;
    reg_dat_di = 8'h41;
    reg_dat_we = 1'b1;
    @(negedge clk);
    reg_dat_we = 1'b0;
    for (int b = 0; b < 10; b++) begin
      err = 1'b0;
      got = exp[b];
      for (int j = 0; j < 16; j++) begin
        if (ser_tx !== exp[b]) begin err = 1'b1; got = ser_tx; end
        if (tdre === 1'b0) low++;
        @(negedge clk);
      end
      tests++; if (err) begin fails++; $display("FAIL tx_bit%0d got %b want %b", b, got, exp[b]); end
    end
    tests++; if (low != 160) begin fails++; $display("FAIL tx_tdre_low_cycles got %0d want 160", low); end
    tests++; if (tdre !== 1'b1) begin fails++; $display("FAIL tx_tdre_after got %b want 1", tdre); end
  endtask

  task automatic test_tx_busy;
    logic [9:0] bits;
    logic       err;
    bits = '0;
    reg_dat_di = 8'h55;
    reg_dat_we = 1'b1;
    @(negedge clk);
    reg_dat_we = 1'b0;
    repeat (4) @(negedge clk);
    reg_dat_di = 8'hAA;
    reg_dat_we = 1'b1;
    #1;
    tests++; if (reg_dat_wait !== 1'b1) begin fails++; $display("FAIL busy_wait got %b want 1", reg_dat_wait); end
    @(negedge clk);
    reg_dat_we = 1'b0;
    #1;
    tests++; if (reg_dat_wait !== 1'b0) begin fails++; $display("FAIL busy_wait_idle got %b want 0", reg_dat_wait); end
    for (int c = 5; c < 160; c++) begin
      if (c % 16 == 8) bits[c/16] = ser_tx;
      @(negedge clk);
    end
    tests++; if (bits !== {1'b1, 8'h55, 1'b0}) begin fails++; $display("FAIL busy_frame got %b want %b", bits, {1'b1, 8'h55, 1'b0}); end
    err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ser_tx !== 1'b1 || tdre !== 1'b1) err = 1'b1;
      @(negedge clk);
    end
    tests++; if (err) begin fails++; $display("FAIL busy_no_second_frame got activity want idle line"); end
  endtask

  task automatic test_rx;
    send_rx(8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (recv_buf_valid !== 1'b1) begin fails++; $display("FAIL rx_valid got %b want 1", recv_buf_valid); end
    tests++; if (reg_dat_do !== 8'hC3) begin fails++; $display("FAIL rx_data got %h want c3", reg_dat_do); end
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL rx_valid_pop got %b want 0", recv_buf_valid); end
    tests++; if (reg_dat_do !== 8'h00) begin fails++; $display("FAIL rx_data_pop got %h want 00", reg_dat_do); end
  endtask

  task automatic test_overrun;
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (rx_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", rx_overrun); end
    tests++; if (recv_buf_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b want 1", recv_buf_valid); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 1);
      tests++; if (reg_dat_do !== exp) begin fails++; $display("FAIL ovr_read%0d got %h want %h", i, reg_dat_do, exp); end
      reg_dat_re = 1'b1;
      @(negedge clk);
      reg_dat_re = 1'b0;
      if (i == 0) begin
        tests++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", rx_overrun); end
      end
    end
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL ovr_drained got %b want 0", recv_buf_valid); end
    tests++; if (reg_dat_do !== 8'h00) begin fails++; $display("FAIL ovr_drained_do got %h want 00", reg_dat_do); end
  endtask

  task automatic test_glitch_framing;
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b want 0", recv_buf_valid); end
    send_rx(8'h5A, 1'b0);
    repeat (100) @(negedge clk);
    ser_rx = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL frame_err_valid got %b want 0", recv_buf_valid); end
    tests++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL frame_err_overrun got %b want 0", rx_overrun); end
    send_rx(8'h7E, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (recv_buf_valid !== 1'b1) begin fails++; $display("FAIL after_break_valid got %b want 1", recv_buf_valid); end
    tests++; if (reg_dat_do !== 8'h7E) begin fails++; $display("FAIL after_break_data got %h want 7e", reg_dat_do); end
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] rx_bits;
    rx_bits = {1'b1, 8'hA5, 1'b0};
    reg_dat_di = 8'h00;
    for (int c = 0; c < 104; c++) begin
      ser_rx = rx_bits[c/16];
      reg_dat_we = (c == 35);
      @(negedge clk);
    end
    reg_dat_we = 1'b0;
    tests++; if (tdre !== 1'b0 || ser_tx !== 1'b0) begin fails++; $display("FAIL mid_busy got tdre=%b ser_tx=%b want 0/0", tdre, ser_tx); end
    resetn = 1'b0;
    ser_rx = 1'b1;
    #1;
    tests++; if (ser_tx !== 1'b1) begin fails++; $display("FAIL mid_reset_ser_tx got %b want 1", ser_tx); end
    tests++; if (tdre !== 1'b1) begin fails++; $display("FAIL mid_reset_tdre got %b want 1", tdre); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    tests++; if (recv_buf_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %b want 0", recv_buf_valid); end
    tests++; if (ser_tx !== 1'b1 || tdre !== 1'b1) begin fails++; $display("FAIL mid_reset_idle got ser_tx=%b tdre=%b want 1/1", ser_tx, tdre); end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_tx_busy;
    test_rx;
    test_overrun;
    test_glitch_framing;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
